upscaler_top: RTL and testbench

Streaming 24-bit RGB smoothing stage for the image upscaler. It consumes a pre-replicated nearest-neighbour stream and emits one filtered pixel per accepted input pixel. The stream is IMG_W×IMG_H source pixels, each repeated SCALE times horizontally and each line repeated SCALE times vertically. A causal 2×2 per-channel average removes blockiness before the frame is written out.

---
 rtl/upscaler_pkg.sv | 33 +++
 rtl/line_buffer.sv | 35 +++
 rtl/upscaler_top.sv | 147 ++++++++++++++
 tb/tb_upscaler_top.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/upscaler_pkg.sv
// upscaler_pkg
//   Shared types and helpers for the upscaler smoothing stage.
//   pixel_t     : 24-bit packed RGB, element [2]=R, [1]=G, [0]=B.
//   CH_R/G/B    : channel indices into pixel_t.
//   out_dim()   : scaled frame dimension (source size * scale).
//   cnt_w()     : counter width able to index 0..n-1.
//   avg4()      : rounded mean of four 8-bit samples.
package upscaler_pkg;

  typedef logic [2:0][7:0] pixel_t;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  function automatic int out_dim(input int img, input int scale);
    return img * scale;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Four 8-bit values plus rounding constant fit in 10 bits, so the
  // result never overflows 8 bits.
  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = 10'(a) + 10'(b) + 10'(c) + 10'(d) + 10'd2;
    return sum[9:2];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer
//   One-row pixel store, simple dual-port, read-before-write when both
//   ports hit the same address in the same cycle. Registered read data.
//   clk     : clock
//   rd_en   : capture mem[rd_addr] into rd_data on this edge
//   rd_addr : read address
//   rd_data : registered read data (previous contents on a same-address write)
//   wr_en   : write wr_data to mem[wr_addr] on this edge
//   wr_addr : write address
//   wr_data : write data
module line_buffer
  import upscaler_pkg::*;
#(
  parameter int DEPTH = 1152,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pixel_t        wr_data
);

  pixel_t mem [DEPTH];

  // NOTE: storage arrays get no reset so they map onto block RAM; the
  // consumer never uses a location before writing it in the current frame.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/upscaler_top.sv
// upscaler_top
//   Causal 2x2 per-channel smoothing of a nearest-neighbour upscaled RGB
//   raster. One output per accepted input, fixed 2-cycle latency.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   pixel_in     : {R,G,B} stream pixel
//   input_valid  : pixel_in accepted on this edge
//   pixel_out    : filtered pixel, held while output_valid is low
//   output_valid : pixel_out carries a new result
module upscaler_top
  import upscaler_pkg::*;
#(
  parameter int IMG_W = 384,
  parameter int IMG_H = 216,
  parameter int SCALE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        input_valid,
  output logic [23:0] pixel_out,
  output logic        output_valid
);

  localparam int OUT_W = out_dim(IMG_W, SCALE);
  localparam int OUT_H = out_dim(IMG_H, SCALE);
  localparam int COL_W = cnt_w(OUT_W);
  localparam int ROW_W = cnt_w(OUT_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Stage 1: current pixel, left neighbour, edge flags, previous buffer read.
  pixel_t s1_p_q, s1_p_d, s1_l_q, s1_l_d, ul_raw_q, ul_raw_d;
  logic   s1_row0_q, s1_row0_d, s1_col0_q, s1_col0_d;
  // Stage 1b: all four neighbours resolved against the frame edges.
  pixel_t s2_p_q, s2_p_d, s2_l_q, s2_l_d, s2_u_q, s2_u_d, s2_ul_q, s2_ul_d;
  // Stage 2: rounded average.
  pixel_t pix_out_q, pix_out_d;
  logic   v1_q, v2_q, ov_q;

  pixel_t rd_data, up, upleft;

  line_buffer #(.DEPTH(OUT_W), .AW(COL_W)) u_line_buffer (
    .clk     (clk),
    .rd_en   (input_valid),
    .rd_addr (col_q),
    .rd_data (rd_data),
    .wr_en   (input_valid),
    .wr_addr (col_q),
    .wr_data (pixel_in)
  );

  // NOTE: every signal written here gets a default first, so no latch is
  // inferred on paths that leave it unassigned.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    s1_p_d    = s1_p_q;
    s1_l_d    = s1_l_q;
    s1_row0_d = s1_row0_q;
    s1_col0_d = s1_col0_q;
    ul_raw_d  = ul_raw_q;
    s2_p_d    = s2_p_q;
    s2_l_d    = s2_l_q;
    s2_u_d    = s2_u_q;
    s2_ul_d   = s2_ul_q;
    pix_out_d = pix_out_q;

    if (input_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      s1_p_d    = pixel_in;
      // s1_p_q only moves on accepted beats, so it is the left neighbour.
      s1_l_d    = (col_q == '0) ? pixel_t'(pixel_in) : s1_p_q;
      s1_row0_d = (row_q == '0);
      s1_col0_d = (col_q == '0);
      // The buffer output still holds last beat's read, i.e. p(r-1,c-1).
      ul_raw_d  = rd_data;
    end

    // Row 0 must not see buffer contents (stale or never written).
    up     = s1_row0_q ? s1_p_q : rd_data;
    upleft = s1_row0_q ? s1_l_q : (s1_col0_q ? up : ul_raw_q);

    if (v1_q) begin
      s2_p_d  = s1_p_q;
      s2_l_d  = s1_l_q;
      s2_u_d  = up;
      s2_ul_d = upleft;
    end

    if (v2_q) begin
      pix_out_d[CH_R] = avg4(s2_p_q[CH_R], s2_l_q[CH_R], s2_u_q[CH_R], s2_ul_q[CH_R]);
      pix_out_d[CH_G] = avg4(s2_p_q[CH_G], s2_l_q[CH_G], s2_u_q[CH_G], s2_ul_q[CH_G]);
      pix_out_d[CH_B] = avg4(s2_p_q[CH_B], s2_l_q[CH_B], s2_u_q[CH_B], s2_ul_q[CH_B]);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      s1_p_q    <= '0;
      s1_l_q    <= '0;
      s1_row0_q <= 1'b0;
      s1_col0_q <= 1'b0;
      ul_raw_q  <= '0;
      s2_p_q    <= '0;
      s2_l_q    <= '0;
      s2_u_q    <= '0;
      s2_ul_q   <= '0;
      pix_out_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      s1_p_q    <= s1_p_d;
      s1_l_q    <= s1_l_d;
      s1_row0_q <= s1_row0_d;
      s1_col0_q <= s1_col0_d;
      ul_raw_q  <= ul_raw_d;
      s2_p_q    <= s2_p_d;
      s2_l_q    <= s2_l_d;
      s2_u_q    <= s2_u_d;
      s2_ul_q   <= s2_ul_d;
      pix_out_q <= pix_out_d;
      v1_q      <= input_valid;
      v2_q      <= v1_q;
      ov_q      <= v2_q;
    end
  end

  assign pixel_out    = pix_out_q;
  assign output_valid = ov_q;

endmodule

// File: tb/tb_upscaler_top.sv
// tb_upscaler_top
//   Directed bench for upscaler_top on a reduced 4x3 source (12x9 scaled),
//   so full frames stay short. Expected values are hand-derived constants.
module tb_upscaler_top;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int SCALE = 3;
  localparam int OUT_W = IMG_W * SCALE;
  localparam int OUT_H = IMG_H * SCALE;
  localparam int FRAME = OUT_W * OUT_H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        input_valid = 1'b0;
  logic [23:0] pixel_out;
  logic        output_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] out_q[$];
  logic        ov_hist[$];
  logic        iv_hist[$];

  always #5 clk = ~clk;

  upscaler_top #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .input_valid  (input_valid),
    .pixel_out    (pixel_out),
    .output_valid (output_valid)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: sample outputs at the falling edge, then drive.
  task automatic beat(input logic [23:0] p, input logic v);
    @(negedge clk);
    ov_hist.push_back(output_valid);
    if (output_valid) out_q.push_back(pixel_out);
    pixel_in    = p;
    input_valid = v;
    iv_hist.push_back(v);
  endtask

  task automatic flush();
    repeat (4) beat(24'h0, 1'b0);
  endtask

  task automatic clear_hist();
    out_q.delete();
    ov_hist.delete();
    iv_hist.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    input_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [23:0] got(input int i);
    return (i < out_q.size()) ? out_q[i] : 24'hxxxxxx;
  endfunction

  // Vertical-step frame: scaled rows 0-2 black, rows 3-8 pure blue.
  function automatic logic [23:0] vert_src(input int r);
    return (r < 3) ? 24'h000000 : 24'h0000FF;
  endfunction

  function automatic logic [23:0] vert_exp(input int r);
    if (r < 3)  return 24'h000000;
    if (r == 3) return 24'h000080;   // (FF+FF+00+00+2)>>2
    return 24'h0000FF;
  endfunction

  task automatic feed_vert_frame(input logic gaps);
    for (int r = 0; r < OUT_H; r++) begin
      for (int c = 0; c < OUT_W; c++) beat(vert_src(r), 1'b1);
      if (gaps) beat(24'h0, 1'b0);
    end
  endtask

  initial begin
    // Reset held with valid traffic: nothing comes out.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat(24'hABCDEF, 1'b1);
      check("reset_ov", 24'(output_valid), 24'h0);
    end
    check("reset_pix", pixel_out, 24'h000000);
    check("reset_cnt", 24'(out_q.size()), 24'd0);

    // Release; a single pixel is (0,0), all neighbours collapse onto it.
    @(negedge clk);
    input_valid = 1'b0;
    rst = 1'b1;
    clear_hist();
    beat(24'h123456, 1'b1);
    beat(24'h0, 1'b0);
    beat(24'h0, 1'b0);
    beat(24'h0, 1'b0);
    beat(24'h0, 1'b0);
    check("lat_ov_e0", 24'(ov_hist[1]), 24'h0);
    check("lat_ov_e1", 24'(ov_hist[2]), 24'h0);
    check("lat_ov_e2", 24'(ov_hist[3]), 24'h1);
    check("lat_ov_e3", 24'(ov_hist[4]), 24'h0);
    check("lat_pix", got(0), 24'h123456);
    check("hold_pix", pixel_out, 24'h123456);
    check("hold_ov", 24'(output_valid), 24'h0);

    // Horizontal step on row 0.
    do_reset();
    clear_hist();
    for (int c = 0; c < OUT_W; c++) beat((c < 3) ? 24'h000000 : 24'hFFFFFF, 1'b1);
    flush();
    check("hstep_cnt", 24'(out_q.size()), 24'(OUT_W));
    check("hstep_c0", got(0), 24'h000000);
    check("hstep_c1", got(1), 24'h000000);
    check("hstep_c2", got(2), 24'h000000);
    check("hstep_c3", got(3), 24'h808080);
    check("hstep_c4", got(4), 24'hFFFFFF);
    check("hstep_c5", got(5), 24'hFFFFFF);

    // Vertical step over a full frame, then row 0 of the next frame, which
    // must ignore the blue left in the line buffer.
    do_reset();
    clear_hist();
    feed_vert_frame(1'b0);
    for (int c = 0; c < OUT_W; c++) beat(24'h00FF00, 1'b1);
    flush();
    check("vstep_cnt", 24'(out_q.size()), 24'(FRAME + OUT_W));
    for (int i = 0; i < FRAME; i++) check("vstep_pix", got(i), vert_exp(i / OUT_W));
    for (int c = 0; c < OUT_W; c++) check("wrap_row0", got(FRAME + c), 24'h00FF00);

    // Same frame with a one-cycle gap after every line.
    do_reset();
    clear_hist();
    feed_vert_frame(1'b1);
    flush();
    check("gap_cnt", 24'(out_q.size()), 24'(FRAME));
    for (int i = 0; i < FRAME; i++) check("gap_pix", got(i), vert_exp(i / OUT_W));
    for (int j = 0; j + 3 < iv_hist.size(); j++)
      check("gap_ov_delay", 24'(ov_hist[j+3]), 24'(iv_hist[j]));

    // Reset in the middle of a frame, then a flat frame from (0,0).
    do_reset();
    clear_hist();
    for (int i = 0; i < 6 * OUT_W + 5; i++) beat(vert_src(i / OUT_W), 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      beat(24'h777777, 1'b1);
      check("midrst_ov", 24'(output_valid), 24'h0);
      check("midrst_pix", pixel_out, 24'h000000);
    end
    @(negedge clk);
    input_valid = 1'b0;
    rst = 1'b1;
    clear_hist();
    for (int i = 0; i < FRAME; i++) beat(24'h3366CC, 1'b1);
    flush();
    check("flat_cnt", 24'(out_q.size()), 24'(FRAME));
    for (int i = 0; i < FRAME; i++) check("flat_pix", got(i), 24'h3366CC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
